// File: rtl/stat_engine_arbiter_if.sv
// stat_engine_arbiter_if: requester, grant/done and engine-side signals of the stat-engine arbiter.
interface stat_engine_arbiter_if #(
   parameter int DW = 4,
   parameter int OW = 11
);
   logic          req0, req1;
   logic          in_valid0, in_valid1;
   logic [DW-1:0] in0, in1;
   logic [1:0]    mode0, mode1;
   logic          gnt0, gnt1;
   logic          done0, done1;
   logic [OW-1:0] result;
   logic          eng_in_valid;
   logic [DW-1:0] eng_in;
   logic [1:0]    eng_mode;
   logic          eng_out_valid;
   logic [OW-1:0] eng_out;
   modport master (
      output req0, req1, in_valid0, in_valid1, in0, in1, mode0, mode1, eng_out_valid, eng_out,
      input  gnt0, gnt1, done0, done1, result, eng_in_valid, eng_in, eng_mode
   );
   modport slave (
      input  req0, req1, in_valid0, in_valid1, in0, in1, mode0, mode1, eng_out_valid, eng_out,
      output gnt0, gnt1, done0, done1, result, eng_in_valid, eng_in, eng_mode
   );
endinterface

// File: rtl/stat_engine_arbiter.sv
// stat_engine_arbiter: two-requester arbiter/sequencer owning the digit-statistics engine one frame at a time.
// Round-robin by default; define ARB_FIXED_PRIO_EN for fixed priority (req0 always wins).
module stat_engine_arbiter #(
   parameter int DW = 4,
   parameter int OW = 11
) (
   input logic                  clk,
   input logic                  rst_n,
   stat_engine_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, STREAM, COMPUTE, RETURN} state_t;
   state_t        state, state_n;
   logic          owner, winner;
   logic          grant, abandon, load_mode, capture, take;
   logic          own_req, own_vld;
   logic [DW-1:0] own_in;
   logic [1:0]    own_mode;
   logic [4:0]    cnt;
   assign own_req  = owner ? bus.req1 : bus.req0;
   assign own_vld  = owner ? bus.in_valid1 : bus.in_valid0;
   assign own_in   = owner ? bus.in1 : bus.in0;
   assign own_mode = owner ? bus.mode1 : bus.mode0;
`ifdef ARB_FIXED_PRIO_EN
   assign winner = !bus.req0;
`else
   logic last;
   // last holds the most recent owner that completed a frame; the other side wins a tie
   assign winner = (bus.req0 && bus.req1) ? !last : bus.req1;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   always_comb begin
      state_n   = state;
      grant     = 1'b0;
      abandon   = 1'b0;
      load_mode = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            grant   = bus.req0 || bus.req1;
            state_n = grant ? STREAM : IDLE;
         end
         STREAM: begin
            abandon   = !own_req && cnt == 5'd0;
            load_mode = !abandon && !own_vld && cnt != 5'd0;
            state_n   = abandon ? IDLE : load_mode ? COMPUTE : STREAM;
         end
         COMPUTE: begin
            capture = bus.eng_out_valid;
            state_n = capture ? RETURN : COMPUTE;
         end
         default: state_n = IDLE;
      endcase
   end
   assign take = state == STREAM && own_vld && !abandon;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner            <= 1'b0;
         cnt              <= 5'd0;
         bus.gnt0         <= 1'b0;
         bus.gnt1         <= 1'b0;
         bus.done0        <= 1'b0;
         bus.done1        <= 1'b0;
         bus.result       <= '0;
         bus.eng_in_valid <= 1'b0;
         bus.eng_in       <= '0;
         bus.eng_mode     <= 2'd0;
`ifndef ARB_FIXED_PRIO_EN
         last             <= 1'b1;
`endif
      end else begin
         if (grant) begin
            owner    <= winner;
            bus.gnt0 <= !winner;
            bus.gnt1 <= winner;
         end else if (abandon || state == RETURN) begin
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
         end
         cnt              <= grant ? 5'd0 : (take && cnt != 5'd31) ? cnt + 5'd1 : cnt;
         bus.eng_in_valid <= take;
         if (take) bus.eng_in <= own_in;
         if (load_mode) bus.eng_mode <= own_mode;
         if (capture) bus.result <= bus.eng_out;
         bus.done0 <= capture && !owner;
         bus.done1 <= capture && owner;
`ifndef ARB_FIXED_PRIO_EN
         if (state == RETURN) last <= owner;
`endif
      end
   end
endmodule

// File: tb/tb_stat_engine_arbiter.sv
// tb_stat_engine_arbiter: table-driven, directed and randomized checks of stat_engine_arbiter.
// The bench plays both requesters and the engine; expected results come from a histogram model.
module tb_stat_engine_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   stat_engine_arbiter_if #(.DW(4), .OW(11)) bus ();
   stat_engine_arbiter #(.DW(4), .OW(11)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   typedef struct packed {
      logic        who;
      logic [1:0]  mode;
      logic [5:0]  n;
      logic [31:0] d;
      logic [10:0] res;
      logic [1:0]  lat;
   } vec_t;
   vec_t        tbl[6];
   int          n_vec = 0;
   int          n_bad = 0;
   int          last_srv = 1;
   logic [10:0] last_res = '0;
   logic [3:0]  dg[2][64];
   int          dn[2];
   int          dm[2];
   logic [3:0]  ed[64];

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
      end
   endfunction

   function automatic logic gnt(input int w);
      return w[0] ? bus.gnt1 : bus.gnt0;
   endfunction

   function automatic logic done(input int w);
      return w[0] ? bus.done1 : bus.done0;
   endfunction

   // max count, min nonzero count, or digit sum, straight from a histogram
   function automatic logic [10:0] calc(input logic [3:0] a[64], input int n, input int mode);
      int h[16];
      int r;
      for (int j = 0; j < 16; j++) h[j] = 0;
      for (int i = 0; i < n; i++) h[a[i]]++;
      r = (mode == 1) ? 1000 : 0;
      for (int j = 0; j < 16; j++) begin
         if (mode == 0 && h[j] > r) r = h[j];
         if (mode == 1 && h[j] != 0 && h[j] < r) r = h[j];
      end
      if (mode == 2) for (int i = 0; i < n; i++) r += int'(a[i]);
      return 11'(r);
   endfunction

   function automatic int pick(input logic r0, input logic r1);
`ifdef ARB_FIXED_PRIO_EN
      return r0 ? 0 : 1;
`else
      return (r0 && r1) ? 1 - last_srv : (r0 ? 0 : 1);
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int w, input logic v);
      if (w == 0) bus.req0 = v;
      else        bus.req1 = v;
   endtask

   // owner signals as given; the other requester's data lines are noise
   task automatic set_in(input int w, input logic v, input logic [3:0] d);
      if (w == 0) begin
         bus.in_valid0 = v;
         bus.in0       = d;
         bus.mode0     = 2'(dm[0]);
         bus.in_valid1 = 1'($urandom);
         bus.in1       = 4'($urandom);
         bus.mode1     = 2'($urandom);
      end else begin
         bus.in_valid1 = v;
         bus.in1       = d;
         bus.mode1     = 2'(dm[1]);
         bus.in_valid0 = 1'($urandom);
         bus.in0       = 4'($urandom);
         bus.mode0     = 2'($urandom);
      end
   endtask

   task automatic rnd_load(input int w);
      dn[w] = $urandom_range(1, 40);
      dm[w] = $urandom_range(0, 2);
      for (int i = 0; i < dn[w]; i++) dg[w][i] = 4'($urandom_range(0, 6));
   endtask

   task automatic do_reset();
      rst_n             = 1'b0;
      bus.req0          = 1'b0;
      bus.req1          = 1'b0;
      bus.in_valid0     = 1'b0;
      bus.in_valid1     = 1'b0;
      bus.in0           = 4'd0;
      bus.in1           = 4'd0;
      bus.mode0         = 2'd0;
      bus.mode1         = 2'd0;
      bus.eng_out_valid = 1'b0;
      bus.eng_out       = 11'd0;
      tick();
      tick();
      chk("rst_gnt", {bus.gnt1, bus.gnt0}, 0);
      chk("rst_done", {bus.done1, bus.done0}, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_eng_in_valid", bus.eng_in_valid, 0);
      chk("rst_eng_in", bus.eng_in, 0);
      chk("rst_eng_mode", bus.eng_mode, 0);
      rst_n    = 1'b1;
      last_srv = 1;
      last_res = '0;
      tick();
   endtask

   // called in the first cycle gnt is high; returns in the first COMPUTE cycle
   task automatic stream(input int w);
      set_in(w, 1'b1, dg[w][0]);
      for (int i = 0; i < dn[w]; i++) begin
         tick();
         chk("eng_in_valid", bus.eng_in_valid, 1);
         chk("eng_in", bus.eng_in, dg[w][i]);
         chk("gnt_other", gnt(1 - w), 0);
         ed[i] = bus.eng_in;
         set_in(w, i + 1 < dn[w], (i + 1 < dn[w]) ? dg[w][i + 1] : 4'($urandom));
      end
      tick();
      chk("eng_in_valid_fall", bus.eng_in_valid, 0);
      chk("eng_mode", bus.eng_mode, dm[w]);
   endtask

   // the bench engine answers after lat cycles from what it actually received
   task automatic finish(input int w, input int lat, input logic [10:0] res);
      for (int k = 0; k < lat; k++) begin
         chk("done_early", done(w), 0);
         chk("gnt_hold", gnt(w), 1);
         tick();
      end
      bus.eng_out_valid = 1'b1;
      bus.eng_out       = calc(ed, dn[w], int'(bus.eng_mode));
      tick();
      bus.eng_out_valid = 1'b0;
      bus.eng_out       = 11'($urandom);
      chk("done", done(w), 1);
      chk("done_other", done(1 - w), 0);
      chk("result", bus.result, res);
      set_req(w, 1'b0);
      set_in(w, 1'b0, 4'd0);
      tick();
      chk("done_pulse", done(w), 0);
      chk("gnt_release", gnt(w), 0);
      chk("result_hold", bus.result, res);
      last_srv = w;
      last_res = res;
   endtask

   // called in an IDLE cycle with req[w] already high
   task automatic serve(input int w, input logic [10:0] res, input int lat);
      int t = 0;
      do begin
         tick();
         t++;
      end while (gnt(w) !== 1'b1 && t < 20);
      chk("gnt_latency", t, 1);
      chk("gnt_onehot", gnt(1 - w), 0);
      stream(w);
      finish(w, lat, res);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, w2, a, p;
      tbl[0] = '{who: 1'b0, mode: 2'd2, n: 6'd3, d: 32'h0000_0533, res: 11'd11,  lat: 2'd0};
      tbl[1] = '{who: 1'b1, mode: 2'd0, n: 6'd6, d: 32'h0099_9211, res: 11'd3,   lat: 2'd1};
      tbl[2] = '{who: 1'b0, mode: 2'd1, n: 6'd6, d: 32'h0099_9211, res: 11'd1,   lat: 2'd2};
      tbl[3] = '{who: 1'b1, mode: 2'd2, n: 6'd8, d: 32'hFFFF_FFFF, res: 11'd120, lat: 2'd3};
      tbl[4] = '{who: 1'b0, mode: 2'd0, n: 6'd1, d: 32'h0000_0007, res: 11'd1,   lat: 2'd0};
      tbl[5] = '{who: 1'b1, mode: 2'd1, n: 6'd3, d: 32'h0000_0400, res: 11'd1,   lat: 2'd1};
      do_reset();
      foreach (tbl[v]) begin
         w     = int'(tbl[v].who);
         dn[w] = int'(tbl[v].n);
         dm[w] = int'(tbl[v].mode);
         for (int i = 0; i < dn[w]; i++) dg[w][i] = tbl[v].d[i*4 +: 4];
         set_req(w, 1'b1);
         serve(w, tbl[v].res, int'(tbl[v].lat));
      end
      // engine pulse outside COMPUTE must be ignored
      bus.eng_out_valid = 1'b1;
      bus.eng_out       = 11'h555;
      tick();
      bus.eng_out_valid = 1'b0;
      chk("stray_result", bus.result, last_res);
      tick();
      chk("stray_done", {bus.done1, bus.done0}, 0);
      // both requests from reset; the loser waits with noisy data, then the first owner re-requests
      do_reset();
      rnd_load(0);
      rnd_load(1);
      set_req(0, 1'b1);
      set_req(1, 1'b1);
      w = pick(1'b1, 1'b1);
      serve(w, calc(dg[w], dn[w], dm[w]), 1);
      rnd_load(w);
      set_req(w, 1'b1);
      w2 = pick(1'b1, 1'b1);
      serve(w2, calc(dg[w2], dn[w2], dm[w2]), 2);
      serve(1 - w2, calc(dg[1 - w2], dn[1 - w2], dm[1 - w2]), 0);
      // abandon by the requester that did not own last, then a tie must resolve as before
      a = 1 - last_srv;
      set_req(a, 1'b1);
      tick();
      chk("abandon_gnt", gnt(a), 1);
      set_req(a, 1'b0);
      set_in(a, 1'b0, 4'd0);
      tick();
      chk("abandon_release", gnt(a), 0);
      chk("abandon_engine", bus.eng_in_valid, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("abandon_no_done", {bus.done1, bus.done0}, 0);
         chk("abandon_idle", {bus.gnt1, bus.gnt0}, 0);
      end
      rnd_load(0);
      rnd_load(1);
      set_req(0, 1'b1);
      set_req(1, 1'b1);
      w = pick(1'b1, 1'b1);
      serve(w, calc(dg[w], dn[w], dm[w]), 0);
      serve(1 - w, calc(dg[1 - w], dn[1 - w], dm[1 - w]), 1);
      // reset while the engine is computing
      rnd_load(1);
      dm[1] = 2;
      set_req(1, 1'b1);
      tick();
      chk("mid_gnt", bus.gnt1, 1);
      stream(1);
      tick();
      rst_n = 1'b0;
      set_req(1, 1'b0);
      #1;
      chk("mid_rst_gnt", {bus.gnt1, bus.gnt0}, 0);
      chk("mid_rst_done", {bus.done1, bus.done0}, 0);
      chk("mid_rst_result", bus.result, 0);
      chk("mid_rst_eng_mode", bus.eng_mode, 0);
      chk("mid_rst_eng_valid", bus.eng_in_valid, 0);
      tick();
      rst_n             = 1'b1;
      bus.eng_out_valid = 1'b1;
      bus.eng_out       = 11'd77;
      tick();
      bus.eng_out_valid = 1'b0;
      chk("late_result", bus.result, 0);
      chk("late_done", {bus.done1, bus.done0}, 0);
      tick();
      chk("late_done2", {bus.done1, bus.done0}, 0);
      chk("late_gnt", {bus.gnt1, bus.gnt0}, 0);
      last_srv = 1;
      // randomized request patterns, frames, modes and engine latencies
      for (int it = 0; it < 30; it++) begin
         p = $urandom_range(1, 3);
         rnd_load(0);
         rnd_load(1);
         set_req(0, p[0]);
         set_req(1, p[1]);
         w = pick(p[0], p[1]);
         serve(w, calc(dg[w], dn[w], dm[w]), $urandom_range(0, 3));
         if (p == 3) serve(1 - w, calc(dg[1 - w], dn[1 - w], dm[1 - w]), $urandom_range(0, 3));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/stat_engine_arbiter.md
# stat_engine_arbiter

Two-requester arbiter and sequencer for the single digit-statistics engine, which histograms a 4-bit digit stream and returns max-count, min-count or sum. Requesters take turns owning the engine for one frame. The arbiter multiplexes the winner's digit stream and mode onto the engine, waits for the engine's result pulse, and returns the result to the owner with a one-cycle done strobe.

## Interface
- `DW`, default 4: digit width.
- `OW`, default 11: result width.
- `clk` in 1: clock. All logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req0`, `req1` in 1: request engine ownership. Held until the matching done.
- `in_valid0`, `in_valid1` in 1: digit valid from each requester. Ignored unless that requester is granted.
- `in0`, `in1` in DW: digit from each requester.
- `mode0`, `mode1` in 2: operation select. 0 = max count, 1 = min count, 2 = sum. Sampled on the cycle the owner's in_valid first falls.
- `gnt0`, `gnt1` out 1: ownership grant. One-hot or zero.
- `done0`, `done1` out 1: one-cycle result strobe to the owner.
- `result` out OW: result. Valid while done is high and held until the next done.
- `eng_in_valid` out 1: digit valid to the engine.
- `eng_in` out DW: digit to the engine.
- `eng_mode` out 2: mode to the engine.
- `eng_out_valid` in 1: engine result pulse.
- `eng_out` in OW: engine result.

## Operation
- FSM states: IDLE, STREAM, COMPUTE, RETURN. Reset state is IDLE.
- IDLE:
  - `req0`/`req1` are sampled.
  - If any request is high, select a winner, set its gnt, clear the digit counter and go to STREAM.
  - Otherwise stay in IDLE.
- Arbitration: round-robin. `last` pointer resets to 1, so req0 wins the first tie. When both requests are high, the requester not equal to `last` wins. A single request always wins.
- STREAM:
  - `eng_in_valid`/`eng_in` are registered copies of the owner's `in_valid`/`in`.
  - A 5-bit saturating digit counter increments on each owner `in_valid` high.
  - On the first cycle the owner's `in_valid` is low with counter > 0: register the owner's mode into `eng_mode` and go to COMPUTE.
  - If the owner's req is low while the counter is 0, the frame is abandoned. Clear gnt, return to IDLE, no done, `last` unchanged.
- COMPUTE:
  - `eng_in_valid` is 0 and `eng_mode` is held.
  - On `eng_out_valid`, capture `eng_out` into `result` and go to RETURN.
  - There is no timeout; the arbiter waits indefinitely.
- RETURN:
  - Pulse the owner's done for one cycle and clear gnt.
  - Set `last` to the owner.
  - Go to IDLE.
- Non-owner `in_valid`/`in`/`mode` never reach the engine.
- Requests raised during STREAM, COMPUTE or RETURN wait and are evaluated in the next IDLE.
- `eng_out_valid` outside COMPUTE is ignored; `result` is unchanged.
- Reset mid-operation: every register returns to its reset value immediately. gnt drops and no done is issued. The requester must re-request.
- Reset values: `gnt0`=`gnt1`=0, `done0`=`done1`=0, `result`=0, `eng_in_valid`=0, `eng_in`=0, `eng_mode`=0, `last`=1, counter=0.

## Timing
- Grant latency: req high in an IDLE cycle gives gnt high on the next cycle.
- The owner may drive its first digit in the first cycle gnt is high.
- Forward latency: owner digit at cycle t appears on `eng_in_valid`/`eng_in` at t+1.
- `eng_mode` becomes valid in the same cycle `eng_in_valid` first falls, and stays stable until the next frame's mode load.
- Result latency: `eng_out_valid` at cycle t gives done and `result` at t+1. gnt is low from t+2.
- Minimum gap between consecutive frames is two cycles (RETURN then IDLE). This guarantees the engine its idle cycle.
- Back-to-back requests alternate owners with no extra bubble beyond that gap.

## Configuration
- `ARB_FIXED_PRIO_EN` defined: fixed priority. req0 always beats req1 in IDLE. The `last` pointer is not implemented.
- `ARB_FIXED_PRIO_EN` undefined (default): round-robin as described in Operation.

## Test plan
- **Sum:** req0 with digits 3,3,5 and mode0=2. Expected: gnt0 next cycle, engine sees the same digits one cycle later, `eng_mode`=2, done0 with `result`=11, gnt0 low afterwards.
- **Max count:** req1 with digits 1,1,2,9,9,9 and mode1=0. Expected: done1 with `result`=3. gnt0 stays 0 throughout.
- **Simultaneous requests, round-robin:** req0 and req1 both high from reset. Expected: req0 served first, then req1, then req0 again if it re-requests. With `ARB_FIXED_PRIO_EN`, req0 is served whenever both are pending.
- **Isolation:** req1 toggles in_valid1/in1 during req0's frame. Expected: `eng_in` carries only req0's digits, and req1 is granted after done0.
- **Abandon:** req0 raised and granted, then dropped with no digits. Expected: IDLE, no done, engine untouched, `last` unchanged.
- **Reset mid-COMPUTE:** rst_n low during COMPUTE. Expected: all outputs 0 immediately, no done, and a late `eng_out_valid` after reset is ignored.
